// File: rtl/rule_packer.sv
// Packs a stream of rule IDs into wide words, dropping consecutive duplicates
// inside a packet and closing the word on each end-of-packet beat.
module rule_packer #(
  parameter int RULE_WIDTH = 16,
  parameter int PACK = 8,
  localparam int RULE_S_WIDTH = RULE_WIDTH + 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [RULE_S_WIDTH-1:0]      in_data,
  input  logic                         in_valid,
  output logic                         in_ready,
  output logic [PACK*RULE_WIDTH-1:0]   out_data,
  output logic [PACK-1:0]              out_mask,
  output logic                         out_last,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [31:0]                  pkt_cnt,
  output logic [31:0]                  rule_cnt
);

  // in_data layout: last marker in the MSB, rule ID in the low RULE_WIDTH bits.
  typedef struct packed {
    logic                  last;
    logic [RULE_WIDTH-1:0] data;
  } rule_s_t;

  localparam int CNT_W = $clog2(PACK);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] OPEN = 1'b1;

  rule_s_t                           beat;
  logic [0:0]                        state;
  logic [CNT_W-1:0]                  acc_cnt;
  logic [PACK-1:0][RULE_WIDTH-1:0]   lanes;
  logic [PACK-1:0][RULE_WIDTH-1:0]   lanes_next;
  logic [RULE_WIDTH-1:0]             prev_id;
  logic                              prev_valid;
  logic                              accept;
  logic                              dup;
  logic                              pack;
  logic                              full;
  logic                              close;
  logic [PACK-1:0]                   acc_mask;

  assign beat       = rule_s_t'(in_data);
  // prev_id is only meaningful while a packet is open, so the flag is the state itself.
  assign prev_valid = (state == OPEN);
  assign in_ready   = !out_valid || out_ready;
  assign accept     = in_valid && in_ready;
  assign dup        = prev_valid && (beat.data == prev_id);
  assign pack       = accept && !beat.last && !dup;
  assign full       = pack && (acc_cnt == CNT_W'(PACK - 1));
  assign close      = accept && beat.last;

  always_comb begin
    lanes_next = lanes;
    if (pack) lanes_next[acc_cnt] = beat.data;
  end

  always_comb begin
    acc_mask = '0;
    for (int i = 0; i < PACK; i++) acc_mask[i] = (i < int'(acc_cnt));
  end

  // Lanes are cleared whenever a word leaves so unused lanes of later words read zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      acc_cnt <= '0;
      lanes   <= '0;
      prev_id <= '0;
    end else if (close) begin
      state   <= IDLE;
      acc_cnt <= '0;
      lanes   <= '0;
    end else if (pack) begin
      state   <= OPEN;
      prev_id <= beat.data;
      if (full) begin
        acc_cnt <= '0;
        lanes   <= '0;
      end else begin
        acc_cnt <= acc_cnt + CNT_W'(1);
        lanes   <= lanes_next;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_mask  <= '0;
      out_last  <= 1'b0;
    end else if (full) begin
      out_valid <= 1'b1;
      out_data  <= lanes_next;
      out_mask  <= '1;
      out_last  <= 1'b0;
    end else if (close) begin
      out_valid <= 1'b1;
      out_data  <= lanes;
      out_mask  <= acc_mask;
      out_last  <= 1'b1;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pkt_cnt  <= '0;
      rule_cnt <= '0;
    end else if (out_valid && out_ready) begin
      if (out_last) pkt_cnt <= pkt_cnt + 32'd1;
      rule_cnt <= rule_cnt + 32'($countones(out_mask));
    end
  end

endmodule

// File: tb/tb_rule_packer.sv
// Directed bench for rule_packer (PACK=8, RULE_WIDTH=16); a negedge monitor
// records every handshaken output word for the scenario tasks to inspect.
module tb_rule_packer;

  logic         clk = 1'b0;
  logic         rst;
  logic [16:0]  in_data;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] out_data;
  logic [7:0]   out_mask;
  logic         out_last;
  logic         out_valid;
  logic         out_ready;
  logic [31:0]  pkt_cnt;
  logic [31:0]  rule_cnt;

  int checks = 0;
  int errors = 0;

  logic [127:0] q_data[$];
  logic [7:0]   q_mask[$];
  logic         q_last[$];

  rule_packer #(.RULE_WIDTH(16), .PACK(8)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_mask(out_mask), .out_last(out_last), .out_valid(out_valid),
    .out_ready(out_ready), .pkt_cnt(pkt_cnt), .rule_cnt(rule_cnt)
  );

  always #5 clk = ~clk;

  // Inputs change just after posedge, so at negedge a valid&ready pair is a committed handshake.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      q_data.push_back(out_data);
      q_mask.push_back(out_mask);
      q_last.push_back(out_last);
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    q_data.delete(); q_mask.delete(); q_last.delete();
  endtask

  task automatic send(input logic [15:0] id, input logic last);
    int n;
    n = 0;
    in_data  = {last, id};
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!in_ready) begin
      errors++;
      $display("[TB] FAIL send_timeout: id=%0d in_ready=%b required 1", id, in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_words(input int n);
    int t;
    t = 0;
    while (q_data.size() < n && t < 200) begin
      @(posedge clk);
      t++;
    end
    checks++;
    if (q_data.size() < n) begin
      errors++;
      $display("[TB] FAIL word_timeout: got %0d words required %0d", q_data.size(), n);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || out_mask !== 8'h00 || out_data !== 128'h0 || out_last !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_outputs: valid=%b mask=%h last=%b required 0", out_valid, out_mask, out_last);
    end
    checks++;
    if (pkt_cnt !== 32'd0 || rule_cnt !== 32'd0) begin
      errors++;
      $display("[TB] FAIL reset_counters: pkt=%0d rule=%0d required 0", pkt_cnt, rule_cnt);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL reset_in_ready: got %b required 1", in_ready);
    end
  endtask

  task automatic test_basic();
    logic [127:0] e;
    do_reset();
    e = '0; e[0 +: 16] = 16'd5; e[16 +: 16] = 16'd7; e[32 +: 16] = 16'd9;
    send(16'd5, 1'b0); send(16'd7, 1'b0); send(16'd9, 1'b0); send(16'd0, 1'b1);
    wait_words(1);
    idle(2);
    checks++;
    if (q_data[0] !== e || q_mask[0] !== 8'h07 || q_last[0] !== 1'b1) begin
      errors++;
      $display("[TB] FAIL basic_word: data=%h mask=%h last=%b required %h 07 1", q_data[0], q_mask[0], q_last[0], e);
    end
    checks++;
    if (pkt_cnt !== 32'd1 || rule_cnt !== 32'd3 || q_data.size() != 1) begin
      errors++;
      $display("[TB] FAIL basic_counts: pkt=%0d rule=%0d words=%0d required 1 3 1", pkt_cnt, rule_cnt, q_data.size());
    end
  endtask

  task automatic test_wrap();
    logic [127:0] e1, e2;
    do_reset();
    e1 = '0; e2 = '0; e2[0 +: 16] = 16'd9;
    for (int i = 0; i < 8; i++) begin
      e1[i*16 +: 16] = 16'(i + 1);
      send(16'(i + 1), 1'b0);
    end
    send(16'd9, 1'b0); send(16'd0, 1'b1);
    wait_words(2);
    idle(2);
    checks++;
    if (q_data[0] !== e1 || q_mask[0] !== 8'hFF || q_last[0] !== 1'b0) begin
      errors++;
      $display("[TB] FAIL wrap_word1: data=%h mask=%h last=%b required %h ff 0", q_data[0], q_mask[0], q_last[0], e1);
    end
    checks++;
    if (q_data[1] !== e2 || q_mask[1] !== 8'h01 || q_last[1] !== 1'b1) begin
      errors++;
      $display("[TB] FAIL wrap_word2: data=%h mask=%h last=%b required %h 01 1", q_data[1], q_mask[1], q_last[1], e2);
    end
    checks++;
    if (rule_cnt !== 32'd9 || pkt_cnt !== 32'd1) begin
      errors++;
      $display("[TB] FAIL wrap_counts: pkt=%0d rule=%0d required 1 9", pkt_cnt, rule_cnt);
    end
  endtask

  task automatic test_dup();
    logic [127:0] e1, e2;
    do_reset();
    e1 = '0; e1[0 +: 16] = 16'd4; e1[16 +: 16] = 16'd6; e1[32 +: 16] = 16'd4;
    e2 = '0; e2[0 +: 16] = 16'd4;
    send(16'd4, 1'b0); send(16'd4, 1'b0); send(16'd4, 1'b0);
    send(16'd6, 1'b0); send(16'd4, 1'b0); send(16'd0, 1'b1);
    wait_words(1);
    idle(2);
    checks++;
    if (q_data[0] !== e1 || q_mask[0] !== 8'h07 || rule_cnt !== 32'd3) begin
      errors++;
      $display("[TB] FAIL dup_word: data=%h mask=%h rule=%0d required %h 07 3", q_data[0], q_mask[0], rule_cnt, e1);
    end
    send(16'd4, 1'b0); send(16'd0, 1'b1);
    wait_words(2);
    idle(2);
    checks++;
    if (q_data[1] !== e2 || q_mask[1] !== 8'h01 || q_last[1] !== 1'b1) begin
      errors++;
      $display("[TB] FAIL dup_cross_packet: data=%h mask=%h last=%b required %h 01 1", q_data[1], q_mask[1], q_last[1], e2);
    end
  endtask

  task automatic test_empty();
    do_reset();
    send(16'hABCD, 1'b1);
    wait_words(1);
    idle(2);
    checks++;
    if (q_data[0] !== 128'h0 || q_mask[0] !== 8'h00 || q_last[0] !== 1'b1) begin
      errors++;
      $display("[TB] FAIL empty_word: data=%h mask=%h last=%b required 0 00 1", q_data[0], q_mask[0], q_last[0]);
    end
    checks++;
    if (pkt_cnt !== 32'd1 || rule_cnt !== 32'd0) begin
      errors++;
      $display("[TB] FAIL empty_counts: pkt=%0d rule=%0d required 1 0", pkt_cnt, rule_cnt);
    end
  endtask

  task automatic test_backpressure();
    logic [127:0] e1, e2;
    logic stable;
    do_reset();
    e1 = '0; e2 = '0; e2[0 +: 16] = 16'd9; e2[16 +: 16] = 16'd10;
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      e1[i*16 +: 16] = 16'(i + 1);
      send(16'(i + 1), 1'b0);
    end
    in_data = {1'b0, 16'd9};
    in_valid = 1'b1;
    stable = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_data !== e1 || out_mask !== 8'hFF || out_last !== 1'b0)
        stable = 1'b0;
    end
    checks++;
    if (!stable) begin
      errors++;
      $display("[TB] FAIL stall_hold: in_ready=%b valid=%b data=%h mask=%h required 0 1 %h ff", in_ready, out_valid, out_data, out_mask, e1);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    send(16'd9, 1'b0); send(16'd10, 1'b0); send(16'd0, 1'b1);
    wait_words(2);
    idle(3);
    checks++;
    if (q_data.size() != 2 || q_data[0] !== e1 || q_data[1] !== e2 || q_mask[1] !== 8'h03 || q_last[1] !== 1'b1) begin
      errors++;
      $display("[TB] FAIL stall_release: words=%0d w1=%h w2=%h mask2=%h required 2 %h %h 03", q_data.size(), q_data[0], q_data[1], q_mask[1], e1, e2);
    end
    checks++;
    if (rule_cnt !== 32'd10 || pkt_cnt !== 32'd1) begin
      errors++;
      $display("[TB] FAIL stall_counts: pkt=%0d rule=%0d required 1 10", pkt_cnt, rule_cnt);
    end
  endtask

  task automatic test_back_to_back();
    logic [127:0] e2;
    do_reset();
    e2 = '0;
    for (int i = 0; i < 16; i++) begin
      if (i >= 8) e2[(i-8)*16 +: 16] = 16'(i + 1);
      send(16'(i + 1), 1'b0);
    end
    send(16'd0, 1'b1);
    wait_words(3);
    idle(2);
    checks++;
    if (q_data[1] !== e2 || q_mask[1] !== 8'hFF || q_last[1] !== 1'b0) begin
      errors++;
      $display("[TB] FAIL b2b_word2: data=%h mask=%h last=%b required %h ff 0", q_data[1], q_mask[1], q_last[1], e2);
    end
    checks++;
    if (q_data[2] !== 128'h0 || q_mask[2] !== 8'h00 || q_last[2] !== 1'b1 || rule_cnt !== 32'd16) begin
      errors++;
      $display("[TB] FAIL b2b_close: data=%h mask=%h last=%b rule=%0d required 0 00 1 16", q_data[2], q_mask[2], q_last[2], rule_cnt);
    end
  endtask

  task automatic test_reset_mid();
    logic [127:0] e;
    do_reset();
    e = '0; e[0 +: 16] = 16'd2;
    send(16'd7, 1'b0); send(16'd0, 1'b1);
    wait_words(1);
    idle(2);
    send(16'd1, 1'b0); send(16'd2, 1'b0); send(16'd3, 1'b0);
    do_reset();
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || pkt_cnt !== 32'd0 || rule_cnt !== 32'd0) begin
      errors++;
      $display("[TB] FAIL reset_mid_packet: valid=%b pkt=%0d rule=%0d required 0 0 0", out_valid, pkt_cnt, rule_cnt);
    end
    out_ready = 1'b0;
    send(16'd5, 1'b0); send(16'd0, 1'b1);
    do_reset();
    out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || out_mask !== 8'h00) begin
      errors++;
      $display("[TB] FAIL reset_pending: valid=%b mask=%h required 0 00", out_valid, out_mask);
    end
    idle(4);
    checks++;
    if (q_data.size() != 0) begin
      errors++;
      $display("[TB] FAIL reset_no_emit: got %0d words required 0", q_data.size());
    end
    send(16'd2, 1'b0); send(16'd0, 1'b1);
    wait_words(1);
    idle(2);
    checks++;
    if (q_data[0] !== e || q_mask[0] !== 8'h01 || q_last[0] !== 1'b1 || pkt_cnt !== 32'd1 || rule_cnt !== 32'd1) begin
      errors++;
      $display("[TB] FAIL reset_next_packet: data=%h mask=%h pkt=%0d rule=%0d required %h 01 1 1", q_data[0], q_mask[0], pkt_cnt, rule_cnt, e);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_dup();
    test_empty();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
